fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width of every requester and of the FIFO write port.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters, legal range 2..16.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per locked grant, legal range 1..256.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester word available.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_lock, input, NUM_REQ, per-requester burst-hold request.
REQ-009 SHALL have port req_ready, output, NUM_REQ, per-requester word accepted this cycle when high with req_valid.
REQ-010 SHALL have port fifo_wdata, output, DATA_WIDTH, word to the shared FIFO.
REQ-011 SHALL have port fifo_wr, output, 1, FIFO write strobe.
REQ-012 SHALL have port fifo_full, input, 1, FIFO full flag.
REQ-013 SHALL have port grant_id, output, $clog2(NUM_REQ), index of the current grant holder.
REQ-014 SHALL have port busy, output, 1, high while a grant is held.

Function
REQ-015 SHALL implement a two-state FSM: ARB and XFER.
REQ-016 In ARB, if any req_valid is high, SHALL register grant_id = first valid index searching round-robin from last_grant+1 (mod NUM_REQ), and move to XFER at the next edge; otherwise SHALL stay in ARB.
REQ-017 In ARB, req_ready and fifo_wr SHALL be 0.
REQ-018 In XFER, req_ready[grant_id] SHALL be ~fifo_full; all other req_ready bits SHALL be 0.
REQ-019 In XFER, fifo_wr SHALL be req_valid[grant_id] & ~fifo_full, combinationally; fifo_wdata SHALL equal the granted requester's word.
REQ-020 fifo_wdata SHALL be 0 whenever fifo_wr is 0.
REQ-021 A beat SHALL be counted only on a cycle where fifo_wr is high.
REQ-022 With fifo_full high in XFER, the grant SHALL be held with no beat counted and no release.
REQ-023 If req_valid[grant_id] is low in XFER, SHALL return to ARB at the next edge and update last_grant.
REQ-024 Without burst (see Configuration), XFER SHALL end after exactly one beat; next state ARB; last_grant <= grant_id.
REQ-025 Minimum latency: req_valid rising in an ARB cycle yields fifo_wr one cycle later; back-to-back unlocked throughput SHALL be one word per two cycles.
REQ-026 busy SHALL equal (state == XFER).

Reset
REQ-027 On rst, state SHALL be ARB, last_grant NUM_REQ-1 (requester 0 wins first), grant_id 0, beat counter 0.
REQ-028 While rst is high, fifo_wr, req_ready and busy SHALL be forced 0, including mid-XFER; no partial burst SHALL resume after reset.

Configuration
REQ-029 Macro FIFO_WR_ARBITER_BURST_EN SHALL compile burst-lock in: in XFER, after a beat, grant SHALL be held while req_lock[grant_id] is high and beats taken < MAX_BURST; release at the beat reaching MAX_BURST or at the first beat with req_lock low.
REQ-030 Without FIFO_WR_ARBITER_BURST_EN, req_lock SHALL be ignored (port retained) and the beat counter SHALL not exist.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the FSM state typedef (ARB, XFER) and the MAX_NUM_REQ = 16 constant.
REQ-032 Sub-module rr_picker SHALL implement the combinational rotate-priority encoder (inputs valid vector and last index, outputs winner index and any-valid).

Verification
REQ-033 Reset then req_valid=4'b1111, no lock -> grants in order 0,1,2,3,0; fifo_wr pulses every other cycle.
REQ-034 req_valid=4'b0100 only, req_data[2]=8'hA5 -> grant_id=2 one cycle later; fifo_wr=1 with fifo_wdata=8'hA5 for one cycle.
REQ-035 Grant on requester 1, fifo_full=1 for 5 cycles -> req_ready=0, fifo_wr=0, grant_id stays 1; write occurs on the cycle fifo_full falls.
REQ-036 BURST_EN, MAX_BURST=4, requester 3 valid+lock continuously, requester 0 valid -> 4 consecutive writes from 3, then ARB, then requester 0 granted.
REQ-037 BURST_EN, rst asserted on second beat of a locked burst -> fifo_wr=0 that cycle; after reset requester 0 wins with 8'h00 counter.
REQ-038 Granted requester drops req_valid in XFER -> no write, ARB next cycle, next valid requester after it granted.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and limits for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int MAX_NUM_REQ = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: first valid index after last_i, wrapping.
module rr_picker #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] valid_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] winner_o,
    output logic         any_o
);

    // cand[k] is the requester checked at priority position k (0 = highest)
    logic [W-1:0] cand [N];
    logic [N-1:0] rot_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign cand[gi]      = W'((int'(last_i) + gi + 1) % N);
            assign rot_valid[gi] = valid_i[cand[gi]];
        end
    endgenerate

    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                winner_o = cand[k];
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter muxing NUM_REQ requesters onto one FIFO write port.
// Define FIFO_WR_ARBITER_BURST_EN to let a requester hold the grant via req_lock.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic                          fifo_wr,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int GW = $clog2(NUM_REQ);

    arb_state_e      state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   pick_idx;
    logic            pick_any;
    logic [DATA_WIDTH-1:0] word [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_picker #(
        .N (NUM_REQ),
        .W (GW)
    ) u_picker (
        .valid_i  (req_valid),
        .last_i   (last_q),
        .winner_o (pick_idx),
        .any_o    (pick_any)
    );

`ifdef FIFO_WR_ARBITER_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] beat_q, beat_d;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
`ifdef FIFO_WR_ARBITER_BURST_EN
        beat_d     = beat_q;
`endif
        req_ready  = '0;
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        case (state_q)
            ARB: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = XFER;
`ifdef FIFO_WR_ARBITER_BURST_EN
                    beat_d  = '0;
`endif
                end
            end
            XFER: begin
                req_ready[grant_q] = ~fifo_full;
                fifo_wr            = req_valid[grant_q] & ~fifo_full;
                if (fifo_wr) begin
                    fifo_wdata = word[grant_q];
                end
                if (!req_valid[grant_q]) begin
                    state_d = ARB;
                    last_d  = grant_q;
                end else if (!fifo_full) begin
`ifdef FIFO_WR_ARBITER_BURST_EN
                    // the beat just taken counts toward the MAX_BURST limit
                    if (req_lock[grant_q] && (int'(beat_q) + 1 < MAX_BURST)) begin
                        beat_d = beat_q + BW'(1);
                    end else begin
                        beat_d  = '0;
                        state_d = ARB;
                        last_d  = grant_q;
                    end
`else
                    state_d = ARB;
                    last_d  = grant_q;
`endif
                end
            end
            default: state_d = ARB;
        endcase
        if (rst) begin
            req_ready  = '0;
            fifo_wr    = 1'b0;
            fifo_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef FIFO_WR_ARBITER_BURST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end
`endif

    assign grant_id = grant_q;
    assign busy     = (state_q == XFER) & ~rst;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; burst steps run when FIFO_WR_ARBITER_BURST_EN is defined.
module tb_fifo_wr_arbiter;

`ifdef FIFO_WR_ARBITER_BURST_EN
    localparam int TB_MAX_BURST = 4;
`else
    localparam int TB_MAX_BURST = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic [7:0]  fifo_wdata;
    logic        fifo_wr;
    logic        fifo_full;
    logic [1:0]  grant_id;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .MAX_BURST  (TB_MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_lock   (req_lock),
        .req_ready  (req_ready),
        .fifo_wdata (fifo_wdata),
        .fifo_wr    (fifo_wr),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ARB cycle: nothing written, nothing ready, not busy
    task automatic chk_idle(input string tag);
        #1;
        chk({tag, "_wr"}, 32'(fifo_wr), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_wdata"}, 32'(fifo_wdata), 32'd0);
    endtask

    // XFER cycle with a completed write
    task automatic chk_write(input string tag, input logic [1:0] id, input logic [7:0] data);
        #1;
        chk({tag, "_gid"}, 32'(grant_id), 32'(id));
        chk({tag, "_wr"}, 32'(fifo_wr), 32'd1);
        chk({tag, "_wdata"}, 32'(fifo_wdata), 32'(data));
        chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << id));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        $display("txn %s: grant=%0d wdata=%02h", tag, grant_id, fifo_wdata);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h44332211;
        req_lock  = 4'b0000;
        fifo_full = 1'b0;
        tick();
        #1;
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk_idle("rst");

        // all four requesting: grants rotate 0,1,2,3,0 with a write every other cycle
        rst       = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            chk_idle($sformatf("rr%0d_arb", k));
            tick();
            chk_write($sformatf("rr%0d", k), 2'(k % 4), 8'(8'h11 * ((k % 4) + 1)));
            tick();
        end

        // single requester 2 with a distinctive word
        req_valid       = 4'b0100;
        req_data[23:16] = 8'hA5;
        chk_idle("one_arb");
        tick();
        chk_write("one", 2'd2, 8'hA5);
        tick();
        req_valid       = 4'b0000;
        req_data[23:16] = 8'h33;
        chk_idle("one_after");

        // requester 1 granted while the FIFO is full for five cycles
        req_valid = 4'b0010;
        fifo_full = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("full%0d_gid", k), 32'(grant_id), 32'd1);
            chk($sformatf("full%0d_wr", k), 32'(fifo_wr), 32'd0);
            chk($sformatf("full%0d_ready", k), 32'(req_ready), 32'd0);
            chk($sformatf("full%0d_busy", k), 32'(busy), 32'd1);
            tick();
        end
        fifo_full = 1'b0;
        chk_write("full_rel", 2'd1, 8'h22);
        tick();
        req_valid = 4'b0000;
        chk_idle("full_after");

        // granted requester 0 withdraws: no write, then search resumes after 0
        req_valid = 4'b0011;
        tick();
        req_valid = 4'b0010;
        #1;
        chk("drop_gid", 32'(grant_id), 32'd0);
        chk("drop_wr", 32'(fifo_wr), 32'd0);
        chk("drop_wdata", 32'(fifo_wdata), 32'd0);
        chk("drop_busy", 32'(busy), 32'd1);
        tick();
        req_valid = 4'b1001;
        chk_idle("drop_arb");
        tick();
        chk_write("drop_next", 2'd3, 8'h44);
        tick();

        // reset during a transfer forces outputs low and restarts from requester 0
        req_valid = 4'b0100;
        tick();
        rst = 1'b1;
        #1;
        chk("rstx_wr", 32'(fifo_wr), 32'd0);
        chk("rstx_ready", 32'(req_ready), 32'd0);
        chk("rstx_busy", 32'(busy), 32'd0);
        tick();
        #1;
        chk("rstx_gid", 32'(grant_id), 32'd0);
        rst       = 1'b0;
        req_valid = 4'b1111;
        chk_idle("rstx_arb");
        tick();
        chk_write("rstx_first", 2'd0, 8'h11);
        tick();

`ifdef FIFO_WR_ARBITER_BURST_EN
        // locked requester 3 takes exactly MAX_BURST beats, then requester 0
        req_valid = 4'b1001;
        req_lock  = 4'b1000;
        chk_idle("burst_arb");
        tick();
        for (int k = 0; k < 4; k++) begin
            chk_write($sformatf("burst%0d", k), 2'd3, 8'h44);
            tick();
        end
        chk_idle("burst_end");
        tick();
        chk_write("burst_next", 2'd0, 8'h11);
        tick();

        // reset on the second beat of a locked burst
        req_valid = 4'b1000;
        chk_idle("brst_arb");
        tick();
        chk_write("brst_b0", 2'd3, 8'h44);
        tick();
        rst = 1'b1;
        #1;
        chk("brst_wr", 32'(fifo_wr), 32'd0);
        chk("brst_busy", 32'(busy), 32'd0);
        tick();
        rst       = 1'b0;
        req_valid = 4'b1001;
        chk_idle("brst_arb2");
        tick();
        chk_write("brst_first", 2'd0, 8'h11);
        tick();
        req_lock = 4'b0000;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
